// File: rtl/mux2_gate_bank_pkg.sv
// rtl/mux2_gate_bank_pkg.sv - shared parameters for the mux-built gate bank
package mux2_gate_bank_pkg;

  // Operand width used when a module or interface is not given one explicitly
  localparam int DEFAULT_WIDTH = 1;

endpackage : mux2_gate_bank_pkg

// File: rtl/mux2_gate_bank_if.sv
// rtl/mux2_gate_bank_if.sv - operand/result bundle between a driver and the gate bank
interface mux2_gate_bank_if
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_not;

  // Driver side: presents operands, observes registered results
  modport master (
    output in_valid, a, b,
    input  out_valid, y_and, y_nand, y_not
  );

  // Gate bank side: accepts operands, returns registered results
  modport slave (
    input  in_valid, a, b,
    output out_valid, y_and, y_nand, y_not
  );

endinterface : mux2_gate_bank_if

// File: rtl/mux2_gate_bank_gates.sv
// rtl/mux2_gate_bank_gates.sv - NOT, AND and NAND wrappers built only from mux2
module not_gate
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = '1;

  // a=1 picks 0, a=0 picks 1
  mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (a),
    .d1  (ZERO),
    .d0  (ONE),
    .y   (y)
  );

endmodule : not_gate

module and_gate
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  // a=1 passes b through, a=0 forces 0
  mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (a),
    .d1  (b),
    .d0  (ZERO),
    .y   (y)
  );

endmodule : and_gate

module nand_gate
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = '1;

  logic [WIDTH-1:0] b_n;

  // First level: invert b with a mux-built NOT
  mux2 #(.WIDTH(WIDTH)) u_inv_b (
    .sel (b),
    .d1  (ZERO),
    .d0  (ONE),
    .y   (b_n)
  );

  // Second level: a=1 passes NOT b, a=0 forces 1; this is the deepest path
  mux2 #(.WIDTH(WIDTH)) u_sel (
    .sel (a),
    .d1  (b_n),
    .d0  (ONE),
    .y   (y)
  );

endmodule : nand_gate

// File: rtl/mux2_gate_bank_mux2.sv
// rtl/mux2_gate_bank_mux2.sv - bitwise 2:1 multiplexer, the only primitive of the gate library
module mux2
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] y
);

  // Each bit selects independently; X on sel propagates per ?: semantics
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = sel[i] ? d1[i] : d0[i];
  end

endmodule : mux2

// File: rtl/mux2_gate_bank.sv
// rtl/mux2_gate_bank.sv - registered bank of mux-built AND, NAND and NOT with valid strobe
module mux2_gate_bank
  import mux2_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mux2_gate_bank_if.slave bus
);

  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] nand_c;
  logic [WIDTH-1:0] not_c;

  logic [WIDTH-1:0] y_and_d,  y_and_q;
  logic [WIDTH-1:0] y_nand_d, y_nand_q;
  logic [WIDTH-1:0] y_not_d,  y_not_q;
  logic             valid_d,  valid_q;

  and_gate #(.WIDTH(WIDTH)) u_and (
    .a (bus.a),
    .b (bus.b),
    .y (and_c)
  );

  nand_gate #(.WIDTH(WIDTH)) u_nand (
    .a (bus.a),
    .b (bus.b),
    .y (nand_c)
  );

  not_gate #(.WIDTH(WIDTH)) u_not (
    .a (bus.a),
    .y (not_c)
  );

  // Load new results on an accepted sample, otherwise hold; valid tracks acceptance
  always_comb begin
    y_and_d  = y_and_q;
    y_nand_d = y_nand_q;
    y_not_d  = y_not_q;
    valid_d  = bus.in_valid;
    if (bus.in_valid) begin
      y_and_d  = and_c;
      y_nand_d = nand_c;
      y_not_d  = not_c;
    end
  end

  // Result and valid registers; reset wins over a same-edge sample
  always_ff @(posedge clk) begin
    if (rst) begin
      y_and_q  <= '0;
      y_nand_q <= '0;
      y_not_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      y_and_q  <= y_and_d;
      y_nand_q <= y_nand_d;
      y_not_q  <= y_not_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.y_and     = y_and_q;
  assign bus.y_nand    = y_nand_q;
  assign bus.y_not     = y_not_q;
  assign bus.out_valid = valid_q;

endmodule : mux2_gate_bank

// File: tb/tb_mux2_gate_bank.sv
// tb/tb_mux2_gate_bank.sv - self-checking bench for mux2_gate_bank at WIDTH 1 and 4
module tb_mux2_gate_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mux2_gate_bank_if #(.WIDTH(1)) if1 ();
  mux2_gate_bank_if #(.WIDTH(4)) if4 ();

  mux2_gate_bank #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  mux2_gate_bank #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    if4.in_valid = 1'b1; if4.a = 4'hF; if4.b = 4'hF;
    tick();
    tick();
    checks++;
    if ({if1.out_valid, if1.y_and, if1.y_nand, if1.y_not} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1: got v/and/nand/not=%b%b%b%b want 0000",
               if1.out_valid, if1.y_and, if1.y_nand, if1.y_not);
    end
    checks++;
    if ({if4.out_valid, if4.y_and, if4.y_nand, if4.y_not} !== 13'd0) begin
      errors++;
      $display("FAIL reset_w4: got v=%b and=%h nand=%h not=%h want all 0",
               if4.out_valid, if4.y_and, if4.y_nand, if4.y_not);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] exp_tab [4];
    exp_tab[0] = 3'b011;
    exp_tab[1] = 3'b011;
    exp_tab[2] = 3'b010;
    exp_tab[3] = 3'b100;
    rst = 1'b0;
    if4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      if1.in_valid = 1'b1;
      if1.a = ab[1];
      if1.b = ab[0];
      tick();
      checks++;
      if ({if1.y_and, if1.y_nand, if1.y_not} !== exp_tab[i] || if1.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL truth_ab%b: got v=%b and/nand/not=%b%b%b want v=1 %b",
                 ab, if1.out_valid, if1.y_and, if1.y_nand, if1.y_not, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold();
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    tick();
    checks++;
    if ({if1.out_valid, if1.y_and, if1.y_nand, if1.y_not} !== 4'b1100) begin
      errors++;
      $display("FAIL hold_accept: got %b%b%b%b want 1100",
               if1.out_valid, if1.y_and, if1.y_nand, if1.y_not);
    end
    if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({if1.out_valid, if1.y_and, if1.y_nand, if1.y_not} !== 4'b0100) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %b%b%b%b want 0100",
                 k, if1.out_valid, if1.y_and, if1.y_nand, if1.y_not);
      end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
    tick();
    checks++;
    if ({if1.out_valid, if1.y_and, if1.y_nand, if1.y_not} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_priority: got %b%b%b%b want 0000",
               if1.out_valid, if1.y_and, if1.y_nand, if1.y_not);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({if1.out_valid, if1.y_and, if1.y_nand, if1.y_not} !== 4'b1010) begin
      errors++;
      $display("FAIL rst_resume: got %b%b%b%b want 1010",
               if1.out_valid, if1.y_and, if1.y_nand, if1.y_not);
    end
    if1.in_valid = 1'b0;
  endtask

  task automatic test_vector();
    rst = 1'b0;
    if4.in_valid = 1'b1; if4.a = 4'b1100; if4.b = 4'b1010;
    tick();
    checks++;
    if (if4.y_and !== 4'b1000 || if4.y_nand !== 4'b0111 || if4.y_not !== 4'b0011
        || if4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL vector_w4: got v=%b and=%b nand=%b not=%b want 1 1000 0111 0011",
               if4.out_valid, if4.y_and, if4.y_nand, if4.y_not);
    end
    if4.in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic       m_valid;
    logic [3:0] m_and, m_nand, m_not;
    logic       r, iv;
    logic [3:0] ra, rb;
    rst = 1'b1;
    if4.in_valid = 1'b0;
    tick();
    m_valid = 1'b0; m_and = 4'h0; m_nand = 4'h0; m_not = 4'h0;
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      iv = 1'($urandom_range(0, 1));
      ra = 4'($urandom);
      rb = 4'($urandom);
      rst = r;
      if4.in_valid = iv; if4.a = ra; if4.b = rb;
      tick();
      if (r) begin
        m_valid = 1'b0; m_and = 4'h0; m_nand = 4'h0; m_not = 4'h0;
      end else if (iv) begin
        m_valid = 1'b1;
        m_and   = ra & rb;
        m_nand  = ~(ra & rb);
        m_not   = ~ra;
      end else begin
        m_valid = 1'b0;
      end
      checks++;
      if ({if4.out_valid, if4.y_and, if4.y_nand, if4.y_not} !== {m_valid, m_and, m_nand, m_not}) begin
        errors++;
        $display("FAIL random_%0d: got v=%b and=%h nand=%h not=%h want v=%b and=%h nand=%h not=%h",
                 n, if4.out_valid, if4.y_and, if4.y_nand, if4.y_not,
                 m_valid, m_and, m_nand, m_not);
      end
    end
    rst = 1'b0;
    if4.in_valid = 1'b0;
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0;
    test_reset();
    test_truth_table();
    test_hold();
    test_reset_priority();
    test_vector();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux2_gate_bank
